sonic_vc_st_timing_adapter: RTL and testbench



---
 rtl/sonic_vc_st_pkg.sv | 48 ++++
 rtl/sonic_vc_st_timing_adapter_if.sv | 27 ++
 rtl/sonic_vc_st_skid_fifo.sv | 57 +++++
 rtl/sonic_vc_st_timing_adapter.sv | 145 ++++++++++++++
 tb/tb_sonic_vc_st_timing_adapter.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sonic_vc_st_pkg.sv
// rtl/sonic_vc_st_pkg.sv - Shared limits, width helpers and payload packing for the sonic_vc ST adapter
package sonic_vc_st_pkg;

  localparam int MAX_READY_LATENCY = 3;
  localparam int MAX_DATA_W        = 1024;
  localparam int MAX_CHANNEL_W     = 32;
  localparam int MAX_EMPTY_W       = 16;
  localparam int MAX_PAYLOAD_W     = MAX_DATA_W + MAX_CHANNEL_W + MAX_EMPTY_W + 3;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int payload_w(input int data_w, input int channel_w, input int empty_w);
    return data_w + channel_w + empty_w + 3;
  endfunction

  // Packs MSB-first as {data, channel, error, sop, eop, empty}. Callers zero-extend
  // each field and truncate the result to payload_w().
  function automatic logic [MAX_PAYLOAD_W-1:0] pack_payload(
    input int                       channel_w,
    input int                       empty_w,
    input logic [MAX_DATA_W-1:0]    data,
    input logic [MAX_CHANNEL_W-1:0] channel,
    input logic                     error,
    input logic                     sop,
    input logic                     eop,
    input logic [MAX_EMPTY_W-1:0]   empty
  );
    logic [MAX_PAYLOAD_W-1:0] p;
    p = MAX_PAYLOAD_W'(data);
    p = (p << channel_w) | MAX_PAYLOAD_W'(channel);
    p = (p << 1) | MAX_PAYLOAD_W'(error);
    p = (p << 1) | MAX_PAYLOAD_W'(sop);
    p = (p << 1) | MAX_PAYLOAD_W'(eop);
    p = (p << empty_w) | MAX_PAYLOAD_W'(empty);
    return p;
  endfunction

endpackage

// File: rtl/sonic_vc_st_timing_adapter_if.sv
// rtl/sonic_vc_st_timing_adapter_if.sv - Avalon-ST beat bundle used on both sides of the timing adapter
interface sonic_vc_st_timing_adapter_if #(
  parameter int DATA_W    = 128,
  parameter int CHANNEL_W = 1,
  parameter int EMPTY_W   = 2
);

  logic                 ready;
  logic                 valid;
  logic [DATA_W-1:0]    data;
  logic [CHANNEL_W-1:0] channel;
  logic                 error;
  logic                 startofpacket;
  logic                 endofpacket;
  logic [EMPTY_W-1:0]   empty;

  modport master (
    input  ready,
    output valid, data, channel, error, startofpacket, endofpacket, empty
  );

  modport slave (
    output ready,
    input  valid, data, channel, error, startofpacket, endofpacket, empty
  );

endinterface

// File: rtl/sonic_vc_st_skid_fifo.sv
// rtl/sonic_vc_st_skid_fifo.sv - Registered synchronous FIFO that holds in-flight beats of the timing adapter
module sonic_vc_st_skid_fifo
  import sonic_vc_st_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sonic_vc_st_timing_adapter.sv
// rtl/sonic_vc_st_timing_adapter.sv - Avalon-ST ready-latency bridge with credit-tracked skid FIFO
module sonic_vc_st_timing_adapter
  import sonic_vc_st_pkg::*;
#(
  parameter  int DATA_W            = 128,
  parameter  int CHANNEL_W         = 1,
  parameter  int EMPTY_W           = 2,
  parameter  int IN_READY_LATENCY  = 0,
  parameter  int OUT_READY_LATENCY = 2,
  parameter  int DEPTH             = 8,
  localparam int PAYLOAD_W         = payload_w(DATA_W, CHANNEL_W, EMPTY_W),
  localparam int COUNT_W           = clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  sonic_vc_st_timing_adapter_if.slave  sink,
  sonic_vc_st_timing_adapter_if.master source,
  output logic [COUNT_W-1:0]           fill_level,
  output logic                         proto_err
);

  localparam int CSUM_W = COUNT_W + 1;

  if (DEPTH < IN_READY_LATENCY + 2) begin : g_depth_too_small
    $error("sonic_vc_st_timing_adapter: DEPTH must be at least IN_READY_LATENCY+2");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_not_pow2
    $error("sonic_vc_st_timing_adapter: DEPTH must be a power of two");
  end
  if (IN_READY_LATENCY < 0 || IN_READY_LATENCY > MAX_READY_LATENCY ||
      OUT_READY_LATENCY < 0 || OUT_READY_LATENCY > MAX_READY_LATENCY) begin : g_latency_range
    $error("sonic_vc_st_timing_adapter: ready latencies must be within 0..3");
  end
  if (DATA_W > MAX_DATA_W || CHANNEL_W > MAX_CHANNEL_W || EMPTY_W > MAX_EMPTY_W ||
      CHANNEL_W < 1 || EMPTY_W < 1) begin : g_width_range
    $error("sonic_vc_st_timing_adapter: field width out of supported range");
  end

  logic                 ready_en;
  logic                 grant;
  logic                 send_ok;
  logic [COUNT_W-1:0]   outstanding;
  logic [CSUM_W-1:0]    credit_sum;
  logic                 push;
  logic                 pop;
  logic [PAYLOAD_W-1:0] wdata;
  logic [PAYLOAD_W-1:0] rdata;
  logic                 fifo_empty;
  logic                 fifo_full;

  // ready_en keeps in_ready low while reset is held, when fill and credits read zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (sink.valid && !grant) begin
        proto_err <= 1'b1;
      end
    end
  end

  if (IN_READY_LATENCY == 0) begin : g_grant_direct
    assign grant       = sink.ready;
    assign outstanding = '0;
  end else begin : g_grant_delayed
    logic [IN_READY_LATENCY:1] grant_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        grant_d <= '0;
      end else begin
        grant_d[1] <= sink.ready;
        for (int k = 2; k <= IN_READY_LATENCY; k++) begin
          grant_d[k] <= grant_d[k-1];
        end
      end
    end

    // Each grant still in the delay line is a beat that may yet arrive.
    always_comb begin
      outstanding = '0;
      for (int k = 1; k <= IN_READY_LATENCY; k++) begin
        outstanding = outstanding + COUNT_W'(grant_d[k]);
      end
    end

    assign grant = grant_d[IN_READY_LATENCY];
  end

  if (OUT_READY_LATENCY == 0) begin : g_send_direct
    assign send_ok = source.ready;
  end else begin : g_send_delayed
    logic [OUT_READY_LATENCY:1] ready_d;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ready_d <= '0;
      end else begin
        ready_d[1] <= source.ready;
        for (int k = 2; k <= OUT_READY_LATENCY; k++) begin
          ready_d[k] <= ready_d[k-1];
        end
      end
    end

    assign send_ok = ready_d[OUT_READY_LATENCY];
  end

  assign credit_sum = {1'b0, fill_level} + {1'b0, outstanding};
  assign sink.ready = ready_en && (credit_sum < CSUM_W'(DEPTH));
  assign push       = sink.valid && grant && !fifo_full;

  // With a nonzero output latency the downstream has already committed, so every valid pops.
  assign source.valid = !fifo_empty && ((OUT_READY_LATENCY == 0) || send_ok);
  assign pop          = (OUT_READY_LATENCY == 0) ? (source.valid && source.ready) : source.valid;

  assign wdata = PAYLOAD_W'(pack_payload(CHANNEL_W, EMPTY_W,
                                         MAX_DATA_W'(sink.data),
                                         MAX_CHANNEL_W'(sink.channel),
                                         sink.error,
                                         sink.startofpacket,
                                         sink.endofpacket,
                                         MAX_EMPTY_W'(sink.empty)));

  assign {source.data, source.channel, source.error,
          source.startofpacket, source.endofpacket, source.empty} = rdata;

  sonic_vc_st_skid_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fill_level)
  );

endmodule

// File: tb/tb_sonic_vc_st_timing_adapter.sv
// tb/tb_sonic_vc_st_timing_adapter.sv - Directed self-checking bench for the sonic_vc ST timing adapter
module tb_sonic_vc_st_timing_adapter;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic [3:0] fill_a, fill_b, fill_c;
  logic perr_a, perr_b, perr_c;

  always #5 clk = ~clk;

  sonic_vc_st_timing_adapter_if #(.DATA_W(128), .CHANNEL_W(1), .EMPTY_W(2)) a_in ();
  sonic_vc_st_timing_adapter_if #(.DATA_W(128), .CHANNEL_W(1), .EMPTY_W(2)) a_out ();
  sonic_vc_st_timing_adapter_if #(.DATA_W(128), .CHANNEL_W(1), .EMPTY_W(2)) b_in ();
  sonic_vc_st_timing_adapter_if #(.DATA_W(128), .CHANNEL_W(1), .EMPTY_W(2)) b_out ();
  sonic_vc_st_timing_adapter_if #(.DATA_W(64), .CHANNEL_W(4), .EMPTY_W(3)) c_in ();
  sonic_vc_st_timing_adapter_if #(.DATA_W(64), .CHANNEL_W(4), .EMPTY_W(3)) c_out ();

  sonic_vc_st_timing_adapter u_dut_a (
    .clk(clk), .reset(rst_a), .sink(a_in), .source(a_out), .fill_level(fill_a), .proto_err(perr_a)
  );

  sonic_vc_st_timing_adapter #(
    .IN_READY_LATENCY(3), .OUT_READY_LATENCY(2), .DEPTH(8)
  ) u_dut_b (
    .clk(clk), .reset(rst_b), .sink(b_in), .source(b_out), .fill_level(fill_b), .proto_err(perr_b)
  );

  sonic_vc_st_timing_adapter #(
    .DATA_W(64), .CHANNEL_W(4), .EMPTY_W(3), .IN_READY_LATENCY(1), .OUT_READY_LATENCY(0), .DEPTH(8)
  ) u_dut_c (
    .clk(clk), .reset(rst_c), .sink(c_in), .source(c_out), .fill_level(fill_c), .proto_err(perr_c)
  );

  int n_checks = 0;
  int n_fails  = 0;
  logic [159:0] model_a[$];
  logic [159:0] model_b[$];
  logic [159:0] model_c[$];

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mk_a(input int i);
    logic [127:0] d;
    logic         eop;
    d   = {32'hC0DE_0000 + 32'(i), 32'(i * 3), 32'h5A5A_A5A5, ~32'(i)};
    eop = ((i % 10) == 9);
    return {d, 1'(i & 1), ((i % 7) == 0), ((i % 10) == 0), eop, eop ? 2'(i & 3) : 2'd0};
  endfunction

  function automatic logic [73:0] mk_c(input int i);
    logic eop;
    eop = ((i % 4) == 3);
    return {32'hFEED_0000 + 32'(i), 32'(i) * 32'h0101_0101, 4'(i), eop, ((i % 4) == 0), eop, 3'd5};
  endfunction

  function automatic logic [159:0] a_word();
    return 160'({a_out.data, a_out.channel, a_out.error, a_out.startofpacket, a_out.endofpacket, a_out.empty});
  endfunction

  function automatic logic [159:0] b_word();
    return 160'({b_out.data, b_out.channel, b_out.error, b_out.startofpacket, b_out.endofpacket, b_out.empty});
  endfunction

  function automatic logic [159:0] c_word();
    return 160'({c_out.data, c_out.channel, c_out.error, c_out.startofpacket, c_out.endofpacket, c_out.empty});
  endfunction

  task automatic drive_a(input logic [133:0] w);
    a_in.valid = 1'b1;
    {a_in.data, a_in.channel, a_in.error, a_in.startofpacket, a_in.endofpacket, a_in.empty} = w;
  endtask

  task automatic drive_b(input logic [133:0] w);
    b_in.valid = 1'b1;
    {b_in.data, b_in.channel, b_in.error, b_in.startofpacket, b_in.endofpacket, b_in.empty} = w;
  endtask

  task automatic drive_c(input logic [73:0] w);
    c_in.valid = 1'b1;
    {c_in.data, c_in.channel, c_in.error, c_in.startofpacket, c_in.endofpacket, c_in.empty} = w;
  endtask

  task automatic expect_a(input string tag);
    if (model_a.size() > 0) check_eq(tag, a_word(), model_a.pop_front());
    else check_eq("a_spurious_valid", 160'(a_out.valid), 160'(0));
  endtask

  int   first_valid, last_valid, got, sent, cnt, cnt_ready;
  logic [2:0] hist;
  logic hist1;
  logic seen;
  bit   t3_rdy[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit   t3_vld[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  int   t3_fill[6] = '{8, 8, 8, 7, 7, 6};

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    drive_a(134'd0); a_in.valid = 1'b0; a_out.ready = 1'b0;
    drive_b(134'd0); b_in.valid = 1'b0; b_out.ready = 1'b0;
    drive_c(74'd0);  c_in.valid = 1'b0; c_out.ready = 1'b0;
    repeat (3) step();

    // Reset state
    check_eq("rst_a_in_ready",  160'(a_in.ready),  160'(0));
    check_eq("rst_a_out_valid", 160'(a_out.valid), 160'(0));
    check_eq("rst_a_fill",      160'(fill_a),      160'(0));
    check_eq("rst_a_proto_err", 160'(perr_a),      160'(0));
    check_eq("rst_a_payload",   a_word(),          160'(0));
    check_eq("rst_b_in_ready",  160'(b_in.ready),  160'(0));
    check_eq("rst_c_in_ready",  160'(c_in.ready),  160'(0));

    // Test 1: stream from reset release; cycle 1 is the cycle out_ready rises
    rst_a = 1'b0;
    a_out.ready = 1'b1;
    first_valid = 0; last_valid = 0; got = 0; sent = 0;
    for (int cyc = 1; cyc <= 150 && got < 100; cyc++) begin
      if (cyc > 1) step();
      if (sent < 100 && a_in.ready) begin
        drive_a(mk_a(sent));
        model_a.push_back(160'(mk_a(sent)));
        sent++;
      end else begin
        a_in.valid = 1'b0;
      end
      @(negedge clk);
      if (a_out.valid) begin
        if (first_valid == 0) first_valid = cyc;
        last_valid = cyc;
        expect_a("t1_beat");
        got++;
      end
    end
    a_in.valid = 1'b0;
    check_eq("t1_first_valid_cycle", 160'(first_valid), 160'(3));
    check_eq("t1_beats_out", 160'(got), 160'(100));
    check_eq("t1_gapless_span", 160'(last_valid - first_valid + 1), 160'(100));

    // Test 3: fill to 8, then toggle out_ready 1,0,1,0
    a_out.ready = 1'b0;
    repeat (3) step();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (a_in.ready) begin
        drive_a(mk_a(3000 + cnt));
        model_a.push_back(160'(mk_a(3000 + cnt)));
        cnt++;
      end else begin
        a_in.valid = 1'b0;
      end
    end
    step();
    a_in.valid = 1'b0;
    @(negedge clk);
    check_eq("t3_full_fill", 160'(fill_a), 160'(8));
    check_eq("t3_full_in_ready", 160'(a_in.ready), 160'(0));
    check_eq("t3_pushed", 160'(cnt), 160'(8));
    for (int j = 0; j < 6; j++) begin
      step();
      a_out.ready = t3_rdy[j];
      @(negedge clk);
      check_eq($sformatf("t3_out_valid_%0d", j), 160'(a_out.valid), 160'(t3_vld[j]));
      check_eq($sformatf("t3_fill_%0d", j), 160'(fill_a), 160'(t3_fill[j]));
      if (a_out.valid) expect_a("t3_beat");
    end

    // Test 5: set proto_err, stream with fill 5, then reset mid-stream
    step();
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    model_a.delete();
    drive_a(mk_a(999));
    @(negedge clk);
    check_eq("t5_cycle0_in_ready", 160'(a_in.ready), 160'(0));
    step();
    a_in.valid = 1'b0;
    @(negedge clk);
    check_eq("t5_proto_err_set", 160'(perr_a), 160'(1));
    check_eq("t5_dropped_fill", 160'(fill_a), 160'(0));
    cnt = 0;
    for (int i = 0; i < 10 && cnt < 5; i++) begin
      step();
      if (a_in.ready) begin
        drive_a(mk_a(4000 + cnt));
        model_a.push_back(160'(mk_a(4000 + cnt)));
        cnt++;
      end else begin
        a_in.valid = 1'b0;
      end
    end
    step();
    a_in.valid = 1'b0;
    a_out.ready = 1'b1;
    step();
    for (int j = 0; j < 2; j++) begin
      step();
      drive_a(mk_a(4000 + cnt));
      model_a.push_back(160'(mk_a(4000 + cnt)));
      cnt++;
      @(negedge clk);
      check_eq("t5_stream_valid", 160'(a_out.valid), 160'(1));
      check_eq("t5_stream_fill", 160'(fill_a), 160'(5));
      expect_a("t5_stream_beat");
    end
    check_eq("t5_proto_err_sticky", 160'(perr_a), 160'(1));
    step();
    a_in.valid = 1'b0;
    rst_a = 1'b1;
    #1;
    check_eq("t5_rst_out_valid", 160'(a_out.valid), 160'(0));
    check_eq("t5_rst_in_ready", 160'(a_in.ready), 160'(0));
    check_eq("t5_rst_fill", 160'(fill_a), 160'(0));
    check_eq("t5_rst_proto_err", 160'(perr_a), 160'(0));
    check_eq("t5_rst_payload", a_word(), 160'(0));
    model_a.delete();
    step();
    rst_a = 1'b0;
    seen = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (i > 0) step();
      if (a_in.ready) begin
        drive_a(mk_a(5000 + cnt));
        cnt++;
      end else begin
        a_in.valid = 1'b0;
      end
      @(negedge clk);
      if (a_out.valid) begin
        check_eq("t5_first_after_reset", a_word(), 160'(mk_a(5000)));
        seen = 1'b1;
      end
    end
    check_eq("t5_post_reset_beat_seen", 160'(seen), 160'(1));
    step();
    a_in.valid = 1'b0;

    // Test 2: IN_READY_LATENCY=3 credit limit with out_ready held low
    rst_b = 1'b0;
    hist = 3'b000; cnt_ready = 0; cnt = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) step();
      if (hist[2]) begin
        drive_b(mk_a(100 + cnt));
        model_b.push_back(160'(mk_a(100 + cnt)));
        cnt++;
      end else begin
        b_in.valid = 1'b0;
      end
      @(negedge clk);
      if (b_in.ready) cnt_ready++;
      hist = {hist[1:0], b_in.ready};
    end
    check_eq("t2_ready_cycles", 160'(cnt_ready), 160'(8));
    check_eq("t2_beats_sent", 160'(cnt), 160'(8));
    check_eq("t2_fill", 160'(fill_b), 160'(8));
    check_eq("t2_in_ready_low", 160'(b_in.ready), 160'(0));
    check_eq("t2_proto_err", 160'(perr_b), 160'(0));
    step();
    b_in.valid = 1'b0;
    b_out.ready = 1'b1;
    got = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      @(negedge clk);
      if (b_out.valid) begin
        if (model_b.size() > 0) check_eq("t2_drain_beat", b_word(), model_b.pop_front());
        else check_eq("b_spurious_valid", 160'(b_out.valid), 160'(0));
        got++;
      end
    end
    check_eq("t2_drained", 160'(got), 160'(8));
    check_eq("t2_drained_fill", 160'(fill_b), 160'(0));

    // Test 4: IN_READY_LATENCY=1, valid in cycle 1 where the delayed grant is still 0
    rst_c = 1'b0;
    step();
    drive_c(mk_c(77));
    @(negedge clk);
    check_eq("t4_in_ready_now", 160'(c_in.ready), 160'(1));
    check_eq("t4_no_err_yet", 160'(perr_c), 160'(0));
    step();
    c_in.valid = 1'b0;
    @(negedge clk);
    check_eq("t4_proto_err", 160'(perr_c), 160'(1));
    check_eq("t4_fill", 160'(fill_c), 160'(0));
    check_eq("t4_out_valid", 160'(c_out.valid), 160'(0));
    repeat (3) step();
    @(negedge clk);
    check_eq("t4_proto_err_held", 160'(perr_c), 160'(1));
    check_eq("t4_out_valid_held", 160'(c_out.valid), 160'(0));
    hist1 = c_in.ready;

    // Test 6: channel sweep on the 64/4/3 configuration
    c_out.ready = 1'b1;
    got = 0; sent = 0;
    for (int i = 0; i < 40 && got < 16; i++) begin
      step();
      if (hist1 && sent < 16) begin
        drive_c(mk_c(sent));
        model_c.push_back(160'(mk_c(sent)));
        sent++;
      end else begin
        c_in.valid = 1'b0;
      end
      @(negedge clk);
      if (c_out.valid) begin
        if (model_c.size() > 0) check_eq($sformatf("t6_beat_ch%0d", got), c_word(), model_c.pop_front());
        else check_eq("c_spurious_valid", 160'(c_out.valid), 160'(0));
        got++;
      end
      hist1 = c_in.ready;
    end
    c_in.valid = 1'b0;
    check_eq("t6_beats_out", 160'(got), 160'(16));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
